// File: rtl/swerve_seq_pkg.sv
// Shared types and constants for the swerve steering sequencer and its picker.
// Build option SWERVE_SEQ_RR_EN selects round-robin picking (fixed priority otherwise).
package swerve_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    REPORT
  } seq_state_e;

  localparam int ANGLE_W        = 12;
  localparam int LOAD_CYCLES    = 2;
  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_MAX_ACTIVE = 2;
  localparam int DEF_TIMEOUT_W  = 24;
  localparam logic [23:0] DEF_TIMEOUT_CYCLES = 24'd5000000;

  // Index width that stays legal for a single-channel build.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/swerve_seq_picker.sv
// Chooses one channel out of the eligible mask each cycle.
// With SWERVE_SEQ_RR_EN the search rotates from an internal pointer; otherwise lowest index wins.
module swerve_seq_picker
  import swerve_seq_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  localparam int IDX_W = idxWidth(NUM_CH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] eligible_i,
  input  logic              advance_i,
  output logic [NUM_CH-1:0] grant_o,
  output logic [IDX_W-1:0]  index_o
);

`ifdef SWERVE_SEQ_RR_EN
  localparam int SUM_W = IDX_W + 1;

  logic [IDX_W-1:0] ptr_q;
  logic [SUM_W-1:0] sum;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Scan every channel once, starting at the pointer and wrapping at NUM_CH.
  always_comb begin
    grant_o = '0;
    index_o = '0;
    found   = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum = {1'b0, ptr_q} + SUM_W'(k);
      if (sum >= SUM_W'(NUM_CH)) sum = sum - SUM_W'(NUM_CH);
      cand = sum[IDX_W-1:0];
      if (!found && eligible_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        index_o       = cand;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else if (advance_i) begin
      ptr_q <= (index_o == IDX_W'(NUM_CH - 1)) ? '0 : index_o + 1'b1;
    end
  end
`else
  logic found;
  logic unusedInputs;

  assign unusedInputs = clock ^ reset_n ^ advance_i;

  always_comb begin
    grant_o = '0;
    index_o = '0;
    found   = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found && eligible_i[k]) begin
        found      = 1'b1;
        grant_o[k] = 1'b1;
        index_o    = IDX_W'(k);
      end
    end
  end
`endif

endmodule

// File: rtl/swerve_steer_sequencer.sv
// Latches a multi-wheel steering command and dispatches per-channel angle_update pulses under a
// current budget, with per-channel done/timeout tracking. Option: SWERVE_SEQ_RR_EN (round-robin pick).
module swerve_steer_sequencer
  import swerve_seq_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int MAX_ACTIVE = DEF_MAX_ACTIVE,
  parameter int TIMEOUT_W  = DEF_TIMEOUT_W,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = TIMEOUT_W'(DEF_TIMEOUT_CYCLES)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [ANGLE_W*NUM_CH-1:0] cmd_angles_i,
  input  logic [NUM_CH-1:0]         cmd_mask_i,
  input  logic                      abort_i,
  input  logic [NUM_CH-1:0]         at_target_i,
  input  logic [NUM_CH-1:0]         angle_done_i,
  output logic [ANGLE_W*NUM_CH-1:0] target_angle_o,
  output logic [NUM_CH-1:0]         angle_update_o,
  output logic                      busy_o,
  output logic [NUM_CH-1:0]         ch_fault_o,
  output logic                      seq_done_o
);

  localparam int IDX_W = idxWidth(NUM_CH);
  localparam int CNT_W = $clog2(NUM_CH + 1);

  seq_state_e                              state_q, state_d;
  logic [1:0]                              loadCnt_q, loadCnt_d;
  logic [NUM_CH-1:0]                       pending_q, pending_d;
  logic [NUM_CH-1:0]                       active_q, active_d;
  logic [NUM_CH-1:0][TIMEOUT_W-1:0]        timer_q, timer_d;
  logic [NUM_CH-1:0][ANGLE_W-1:0]          target_q, target_d;
  logic [NUM_CH-1:0]                       update_q, update_d;
  logic                                    busy_q, busy_d;
  logic [NUM_CH-1:0]                       fault_q, fault_d;

  logic [NUM_CH-1:0][ANGLE_W-1:0]          cmdAngles;
  logic [CNT_W-1:0]                        activeCount;
  logic [NUM_CH-1:0]                       eligible;
  logic [NUM_CH-1:0]                       grant;
  logic [IDX_W-1:0]                        pickIdx;

  assign cmdAngles = cmd_angles_i;

  always_comb begin
    activeCount = '0;
    for (int i = 0; i < NUM_CH; i++) activeCount = activeCount + CNT_W'(active_q[i]);
  end

  // The budget is judged on the slots held at the start of the cycle, so a freed slot is reused next cycle.
  assign eligible = (state_q == RUN && !abort_i && activeCount < CNT_W'(MAX_ACTIVE)) ? pending_q : '0;

  swerve_seq_picker #(.NUM_CH(NUM_CH)) uPicker (
    .clock      (clock),
    .reset_n    (reset_n),
    .eligible_i (eligible),
    .advance_i  (|grant),
    .grant_o    (grant),
    .index_o    (pickIdx)
  );

  always_comb begin
    state_d   = state_q;
    loadCnt_d = loadCnt_q;
    pending_d = pending_q;
    active_d  = active_q;
    timer_d   = timer_q;
    target_d  = target_q;
    update_d  = '0;
    busy_d    = busy_q;
    fault_d   = fault_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (cmd_mask_i[i]) target_d[i] = cmdAngles[i];
          end
          pending_d = cmd_mask_i;
          active_d  = '0;
          fault_d   = '0;
          busy_d    = 1'b1;
          loadCnt_d = '0;
          state_d   = (cmd_mask_i == '0) ? REPORT : LOAD;
        end
      end
      LOAD: begin
        if (abort_i) begin
          pending_d = '0;
          active_d  = '0;
          state_d   = REPORT;
        end else if (loadCnt_q == 2'(LOAD_CYCLES - 1)) begin
          state_d = RUN;
        end else begin
          loadCnt_d = loadCnt_q + 1'b1;
        end
      end
      RUN: begin
        if (abort_i) begin
          pending_d = '0;
          active_d  = '0;
          state_d   = REPORT;
        end else if (pending_q == '0 && active_q == '0) begin
          state_d = REPORT;
        end else begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (active_q[i]) begin
              if (angle_done_i[i]) begin
                active_d[i] = 1'b0;
              end else if (timer_q[i] == '0) begin
                active_d[i] = 1'b0;
                fault_d[i]  = 1'b1;
              end else begin
                timer_d[i] = timer_q[i] - 1'b1;
              end
            end
          end
          // A channel already at target retires straight from pending without using a slot.
          if (grant != '0) begin
            pending_d = pending_q & ~grant;
            if ((grant & at_target_i) == '0) begin
              update_d         = grant;
              active_d         = active_d | grant;
              timer_d[pickIdx] = TIMEOUT_CYCLES;
            end
          end
        end
      end
      REPORT: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      loadCnt_q <= '0;
      pending_q <= '0;
      active_q  <= '0;
      timer_q   <= '0;
      target_q  <= '0;
      update_q  <= '0;
      busy_q    <= 1'b0;
      fault_q   <= '0;
    end else begin
      state_q   <= state_d;
      loadCnt_q <= loadCnt_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      timer_q   <= timer_d;
      target_q  <= target_d;
      update_q  <= update_d;
      busy_q    <= busy_d;
      fault_q   <= fault_d;
    end
  end

  assign cmd_ready_o    = (state_q == IDLE);
  assign seq_done_o     = (state_q == REPORT);
  assign target_angle_o = target_q;
  assign angle_update_o = update_q;
  assign busy_o         = busy_q;
  assign ch_fault_o     = fault_q;

endmodule

// File: tb/tb_swerve_steer_sequencer.sv
// Scoreboard bench for swerve_steer_sequencer: a run-level reference model predicts dispatches and
// run reports, and a separate monitor checks them as the DUT presents them.
module tb_swerve_steer_sequencer;

  localparam int NCH  = 4;
  localparam int MAXA = 2;
  localparam int TOUT = 40;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [47:0]   cmd_angles = '0;
  logic [NCH-1:0] cmd_mask = '0;
  logic          abort = 1'b0;
  logic [NCH-1:0] at_target = '0;
  logic [NCH-1:0] angle_done = '0;
  logic [47:0]   target_angle;
  logic [NCH-1:0] angle_update;
  logic          busy;
  logic [NCH-1:0] ch_fault;
  logic          seq_done;

  always #5 clock = ~clock;

  swerve_steer_sequencer #(
    .NUM_CH(NCH), .MAX_ACTIVE(MAXA), .TIMEOUT_W(24), .TIMEOUT_CYCLES(24'd40)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .cmd_valid_i    (cmd_valid),
    .cmd_ready_o    (cmd_ready),
    .cmd_angles_i   (cmd_angles),
    .cmd_mask_i     (cmd_mask),
    .abort_i        (abort),
    .at_target_i    (at_target),
    .angle_done_i   (angle_done),
    .target_angle_o (target_angle),
    .angle_update_o (angle_update),
    .busy_o         (busy),
    .ch_fault_o     (ch_fault),
    .seq_done_o     (seq_done)
  );

  typedef struct { int cyc; int ch; } dispExp_t;
  typedef struct { int cyc; logic [NCH-1:0] fault; logic [47:0] targets; } repExp_t;

  dispExp_t    dispQ[$];
  repExp_t     repQ[$];
  logic [11:0] modelTarget[NCH];
  int          rrPtr = 0;
  int          runDelay[NCH];
  int          doneRel[NCH];
  int          vectors = 0;
  int          miscompares = 0;
  int          cycleCnt = 0;
  bit          monitorOn = 1'b0;

  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycleCnt);
    end
  endtask

  // Whole-run prediction, edge by edge relative to the accept edge (edge 0).
  task automatic modelRun(input int acc, input logic [NCH-1:0] mask, input logic [NCH-1:0] atT,
                          input logic [47:0] angles, input int abortRel,
                          output int reportRel, output int endRel);
    logic [NCH-1:0] pend, act, nAct, fault;
    logic [47:0]    tg;
    int             dispRel[NCH];
    int             cnt, pick, e;
    pend = mask; act = '0; fault = '0; reportRel = -1;
    for (int i = 0; i < NCH; i++) begin
      doneRel[i] = -1;
      dispRel[i] = 0;
      if (mask[i]) modelTarget[i] = angles[i*12 +: 12];
    end
    if (mask == '0) reportRel = 0;
    for (e = 1; e < 5000 && reportRel < 0; e++) begin
      if (abortRel == e) begin
        reportRel = e;
      end else if (e >= 3) begin
        if (pend == '0 && act == '0) begin
          reportRel = e;
        end else begin
          cnt  = $countones(act);
          nAct = act;
          for (int i = 0; i < NCH; i++) begin
            if (act[i]) begin
              if (doneRel[i] == e) nAct[i] = 1'b0;
              else if (e == dispRel[i] + TOUT + 1) begin
                nAct[i]  = 1'b0;
                fault[i] = 1'b1;
              end
            end
          end
          if (cnt < MAXA && pend != '0) begin
            pick = -1;
`ifdef SWERVE_SEQ_RR_EN
            for (int k = 0; k < NCH; k++)
              if (pick < 0 && pend[(rrPtr + k) % NCH]) pick = (rrPtr + k) % NCH;
            rrPtr = (pick + 1) % NCH;
`else
            for (int k = NCH - 1; k >= 0; k--) if (pend[k]) pick = k;
`endif
            pend[pick] = 1'b0;
            if (!atT[pick]) begin
              dispQ.push_back('{acc + e, pick});
              nAct[pick]    = 1'b1;
              dispRel[pick] = e;
              doneRel[pick] = (runDelay[pick] < 0) ? -1 : e + 1 + runDelay[pick];
            end
          end
          act = nAct;
        end
      end
    end
    for (int i = 0; i < NCH; i++) tg[i*12 +: 12] = modelTarget[i];
    repQ.push_back('{acc + reportRel, fault, tg});
    endRel = reportRel + 1;
    for (int i = 0; i < NCH; i++) if (doneRel[i] > endRel) endRel = doneRel[i];
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] mask, input logic [NCH-1:0] atT,
                               input logic [47:0] angles, input int d0, input int d1,
                               input int d2, input int d3, input int abortRel);
    int guard, acc, reportRel, endRel;
    runDelay = '{d0, d1, d2, d3};
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 300) begin
      @(negedge clock);
      guard++;
    end
    checkOutput("cmd_ready before accept", 64'(cmd_ready), 64'd1);
    cmd_valid  = 1'b1;
    cmd_mask   = mask;
    cmd_angles = angles;
    at_target  = atT;
    acc = cycleCnt + 1;
    modelRun(acc, mask, atT, angles, abortRel, reportRel, endRel);
    for (int rel = 1; rel <= endRel; rel++) begin
      @(negedge clock);
      // Commands offered while the run is busy must be dropped.
      cmd_valid  = (rel <= reportRel + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      cmd_mask   = NCH'($urandom);
      cmd_angles = randAngles();
      for (int i = 0; i < NCH; i++) angle_done[i] = (doneRel[i] == rel);
      abort = (abortRel == rel);
    end
    @(negedge clock);
    checkOutput("busy after run", 64'(busy), 64'd0);
    checkOutput("cmd_ready after run", 64'(cmd_ready), 64'd1);
    cmd_valid  = 1'b0;
    angle_done = '0;
    abort      = 1'b0;
    at_target  = '0;
  endtask

  function automatic logic [47:0] randAngles();
    logic [47:0] a;
    a[31:0]  = $urandom;
    a[47:32] = 16'($urandom);
    return a;
  endfunction

  function automatic int randDelay();
    int d;
    d = int'($urandom_range(0, 60));
    if ($urandom_range(0, 7) == 0) d = -1;
    return d;
  endfunction

  always @(negedge clock) begin
    dispExp_t d;
    repExp_t  r;
    if (monitorOn) begin
      if (dispQ.size() > 0 && dispQ[0].cyc == cycleCnt) begin
        d = dispQ.pop_front();
        checkOutput("angle_update", 64'(angle_update), 64'(1) << d.ch);
      end else if (angle_update != '0) begin
        checkOutput("angle_update unexpected", 64'(angle_update), 64'd0);
      end
      if (repQ.size() > 0 && repQ[0].cyc == cycleCnt) begin
        r = repQ.pop_front();
        checkOutput("seq_done", 64'(seq_done), 64'd1);
        checkOutput("ch_fault at seq_done", 64'(ch_fault), 64'(r.fault));
        checkOutput("target_angle at seq_done", 64'(target_angle), 64'(r.targets));
        checkOutput("busy at seq_done", 64'(busy), 64'd1);
      end else if (seq_done) begin
        checkOutput("seq_done unexpected", 64'(seq_done), 64'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int na, nd, d0, d1, d2, d3, ab;
    logic [NCH-1:0] m, t;
    for (int i = 0; i < NCH; i++) modelTarget[i] = '0;
    repeat (2) @(negedge clock);
    checkOutput("reset target_angle", 64'(target_angle), 64'd0);
    checkOutput("reset angle_update", 64'(angle_update), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset ch_fault", 64'(ch_fault), 64'd0);
    checkOutput("reset seq_done", 64'(seq_done), 64'd0);
    checkOutput("reset cmd_ready", 64'(cmd_ready), 64'd1);
    reset_n   = 1'b1;
    monitorOn = 1'b1;
    @(negedge clock);

    applyStimulus(4'hF, 4'h0, {12'd400, 12'd300, 12'd200, 12'd100}, 50, 50, 50, 50, -1);
    applyStimulus(4'h5, 4'h4, randAngles(), 30, 30, 30, 30, -1);
    applyStimulus(4'hF, 4'h0, randAngles(), 20, -1, 20, 20, -1);
    applyStimulus(4'h1, 4'h0, randAngles(), TOUT, 0, 0, 0, -1);
    applyStimulus(4'h1, 4'h0, randAngles(), TOUT + 1, 0, 0, 0, -1);
    applyStimulus(4'hF, 4'h0, randAngles(), 60, 60, 60, 60, 13);
    applyStimulus(4'hF, 4'h0, randAngles(), 5, 7, 3, 9, -1);
    applyStimulus(4'hF, 4'h0, randAngles(), 4, 4, 4, 4, -1);
    applyStimulus(4'h0, 4'h0, randAngles(), 0, 0, 0, 0, -1);
    applyStimulus(4'hA, 4'h0, randAngles(), 10, 10, 10, 10, 2);

    for (int n = 0; n < 25; n++) begin
      m  = NCH'($urandom);
      t  = ($urandom_range(0, 2) == 0) ? NCH'($urandom) : '0;
      d0 = randDelay(); d1 = randDelay(); d2 = randDelay(); d3 = randDelay();
      ab = -1;
      if ($urandom_range(0, 5) == 0) ab = int'($urandom_range(1, 40));
      applyStimulus(m, t, randAngles(), d0, d1, d2, d3, ab);
    end

    // Reset in the middle of a run abandons it completely.
    monitorOn  = 1'b0;
    cmd_valid  = 1'b1;
    cmd_mask   = 4'hF;
    cmd_angles = randAngles();
    @(negedge clock);
    cmd_valid = 1'b0;
    repeat (6) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("mid-run reset busy", 64'(busy), 64'd0);
    checkOutput("mid-run reset target_angle", 64'(target_angle), 64'd0);
    checkOutput("mid-run reset angle_update", 64'(angle_update), 64'd0);
    checkOutput("mid-run reset cmd_ready", 64'(cmd_ready), 64'd1);
    @(negedge clock);
    reset_n = 1'b1;
    rrPtr   = 0;
    for (int i = 0; i < NCH; i++) modelTarget[i] = '0;
    monitorOn = 1'b1;
    @(negedge clock);
    applyStimulus(4'h6, 4'h0, randAngles(), 8, 8, 8, 8, -1);
    applyStimulus(4'hF, 4'h0, randAngles(), 6, 2, 9, 1, -1);

    repeat (5) @(negedge clock);
    na = dispQ.size();
    nd = repQ.size();
    checkOutput("outstanding dispatches", 64'(na), 64'd0);
    checkOutput("outstanding reports", 64'(nd), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
